// File: rtl/gci_std_display_vram_write_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : gci_std_display_vram_write_combiner
//  Description : Packs single-pixel writes with consecutive addresses into
//                burst writes of up to P_BURST_N 32-bit words for the VRAM
//                memory controller. A partial run is issued on an address
//                break, after P_TIMEOUT idle cycles, or on iFLUSH.
//  Ports       : iCLOCK/inRESET      clock, asynchronous active-low reset
//                iRESET_SYNC         synchronous clear, drops buffered pixels
//                iFLUSH              issue the partial burst now
//                iIF_VALID/oIF_BUSY  pixel write handshake (iIF_ADDR, iIF_DATA)
//                oMEM_VALID/iMEM_BUSY burst word handshake (oMEM_ADDR, oMEM_LEN,
//                                    oMEM_DATA, oMEM_LAST)
//                oEMPTY              combiner idle with nothing buffered
//  Revision    : 1.0  initial release
// ============================================================================
module gci_std_display_vram_write_combiner #(
    parameter int P_MEM_ADDR_N = 23,
    parameter int P_BURST_N    = 8,
    parameter int P_BURST_W    = 3,
    parameter int P_TIMEOUT    = 16,
    parameter int P_TIMEOUT_W  = 5
)(
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    input  logic                    iRESET_SYNC,
    input  logic                    iFLUSH,
    input  logic                    iIF_VALID,
    output logic                    oIF_BUSY,
    input  logic [P_MEM_ADDR_N-1:0] iIF_ADDR,
    input  logic [23:0]             iIF_DATA,
    output logic                    oMEM_VALID,
    input  logic                    iMEM_BUSY,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [P_BURST_W:0]      oMEM_LEN,
    output logic [31:0]             oMEM_DATA,
    output logic                    oMEM_LAST,
    output logic                    oEMPTY
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam int                     C_AW1        = P_MEM_ADDR_N + 1;
    localparam logic [P_BURST_W:0]     C_CNT_ONE    = (P_BURST_W+1)'(1);
    localparam logic [P_BURST_W:0]     C_CNT_FULL   = (P_BURST_W+1)'(P_BURST_N);
    localparam logic [P_BURST_W-1:0]   C_IDX_ONE    = P_BURST_W'(1);
    localparam logic [P_TIMEOUT_W-1:0] C_TMR_ONE    = P_TIMEOUT_W'(1);
    localparam logic [P_TIMEOUT_W-1:0] C_TMR_LAST   = P_TIMEOUT_W'(P_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [P_MEM_ADDR_N-1:0] r_start;
    logic [P_BURST_W:0]      r_count;
    logic [P_TIMEOUT_W-1:0]  r_timer;
    logic [P_BURST_W-1:0]    r_idx;
    logic                    r_pend_valid;
    logic [P_MEM_ADDR_N-1:0] r_pend_addr;
    logic [23:0]             r_pend_data;
    logic [23:0]             r_buf [P_BURST_N];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_last;
    logic [C_AW1-1:0]        w_next_addr;
    logic                    w_contig;
    logic [P_BURST_W:0]      w_count_inc;
    logic [P_TIMEOUT_W-1:0]  w_timer_inc;
    logic                    w_timeout;
    logic                    w_buf_we;
    logic [P_BURST_W-1:0]    w_buf_widx;
    logic [23:0]             w_buf_wdata;

    assign w_issue     = (r_state == ST_ISSUE);
    assign w_accept    = iIF_VALID && !w_issue;
    assign w_xfer      = w_issue && !iMEM_BUSY;
    assign w_last      = w_issue && ({1'b0, r_idx} == (r_count - C_CNT_ONE));
    // One extra bit catches the address wrap: a carry out can never match the
    // zero-extended incoming address, so a wrap always breaks the run.
    assign w_next_addr = {1'b0, r_start} + C_AW1'(r_count);
    assign w_contig    = (w_next_addr == {1'b0, iIF_ADDR});
    assign w_count_inc = r_count + C_CNT_ONE;
    assign w_timer_inc = r_timer + C_TMR_ONE;
    // Timer is 0 on the cycle after an accept, so reaching P_TIMEOUT-1 on the
    // increment puts the first burst word exactly P_TIMEOUT cycles after it.
    assign w_timeout   = (w_timer_inc == C_TMR_LAST);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
        end else if (iRESET_SYNC) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    if (!w_contig || (w_count_inc == C_CNT_FULL) || iFLUSH) begin
                        w_state_next = ST_ISSUE;
                    end
                end else if (iFLUSH || w_timeout) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_xfer && w_last) begin
                    w_state_next = r_pend_valid ? ST_FILL : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (registers only, gated so they read zero outside a burst)
    // ------------------------------------------------------------------------
    always_comb begin
        oIF_BUSY   = w_issue;
        oMEM_VALID = w_issue;
        oEMPTY     = (r_state == ST_IDLE);
        oMEM_LAST  = w_last;
        oMEM_ADDR  = '0;
        oMEM_LEN   = '0;
        oMEM_DATA  = '0;
        if (w_issue) begin
            oMEM_ADDR = r_start;
            oMEM_LEN  = r_count;
            oMEM_DATA = {8'h00, r_buf[r_idx]};
        end
    end

    // ------------------------------------------------------------------------
    // Burst bookkeeping: start address, count, idle timer, word index, pending
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_start      <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_idx        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else if (iRESET_SYNC) begin
            r_start      <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_idx        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_start <= iIF_ADDR;
                        r_count <= C_CNT_ONE;
                        r_timer <= '0;
                        r_idx   <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_contig) begin
                            r_count <= w_count_inc;
                            r_timer <= '0;
                        end else begin
                            r_pend_valid <= 1'b1;
                            r_pend_addr  <= iIF_ADDR;
                            r_pend_data  <= iIF_DATA;
                        end
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                ST_ISSUE: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (r_pend_valid) begin
                                r_start      <= r_pend_addr;
                                r_count      <= C_CNT_ONE;
                                r_timer      <= '0;
                                r_pend_valid <= 1'b0;
                            end else begin
                                r_count <= '0;
                            end
                        end else begin
                            r_idx <= r_idx + C_IDX_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pixel buffer write port. Contents are only read during ISSUE, after
    // being written, so the array carries no reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_widx  = '0;
        w_buf_wdata = iIF_DATA;
        case (r_state)
            ST_IDLE: begin
                w_buf_we = w_accept;
            end
            ST_FILL: begin
                w_buf_we   = w_accept && w_contig;
                w_buf_widx = r_count[P_BURST_W-1:0];
            end
            ST_ISSUE: begin
                w_buf_we    = w_xfer && w_last && r_pend_valid;
                w_buf_wdata = r_pend_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (w_buf_we) begin
            r_buf[w_buf_widx] <= w_buf_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gci_std_display_vram_write_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gci_std_display_vram_write_combiner
//  Description : Self-checking bench for the VRAM write combiner. Directed
//                scenarios followed by randomized traffic, every cycle
//                compared against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gci_std_display_vram_write_combiner;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iRESET_SYNC;
    logic        iFLUSH;
    logic        iIF_VALID;
    logic        oIF_BUSY;
    logic [22:0] iIF_ADDR;
    logic [23:0] iIF_DATA;
    logic        oMEM_VALID;
    logic        iMEM_BUSY;
    logic [22:0] oMEM_ADDR;
    logic [3:0]  oMEM_LEN;
    logic [31:0] oMEM_DATA;
    logic        oMEM_LAST;
    logic        oEMPTY;

    gci_std_display_vram_write_combiner dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iFLUSH      (iFLUSH),
        .iIF_VALID   (iIF_VALID),
        .oIF_BUSY    (oIF_BUSY),
        .iIF_ADDR    (iIF_ADDR),
        .iIF_DATA    (iIF_DATA),
        .oMEM_VALID  (oMEM_VALID),
        .iMEM_BUSY   (iMEM_BUSY),
        .oMEM_ADDR   (oMEM_ADDR),
        .oMEM_LEN    (oMEM_LEN),
        .oMEM_DATA   (oMEM_DATA),
        .oMEM_LAST   (oMEM_LAST),
        .oEMPTY      (oEMPTY)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------------------
    // Reference model: the run being collected, the burst being emitted, and
    // one pixel held back by an address break.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [22:0] a;
        logic [23:0] d;
    } pix_t;

    pix_t        run[$];
    pix_t        pend[$];
    logic [23:0] burst[$];
    logic [22:0] b_addr;
    int          b_len;
    int          idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        run.delete();
        pend.delete();
        burst.delete();
        idle = 0;
    endtask

    task automatic issue_run();
        b_addr = run[0].a;
        b_len  = run.size();
        burst.delete();
        foreach (run[i]) burst.push_back(run[i].d);
        run.delete();
    endtask

    task automatic model_check();
        bit issuing;
        issuing = (burst.size() > 0);
        chk("busy",  {31'b0, oIF_BUSY},   {31'b0, issuing});
        chk("valid", {31'b0, oMEM_VALID}, {31'b0, issuing});
        chk("empty", {31'b0, oEMPTY},     {31'b0, (!issuing && run.size() == 0)});
        chk("last",  {31'b0, oMEM_LAST},  {31'b0, (issuing && burst.size() == 1)});
        if (issuing) begin
            chk("addr", {9'b0, oMEM_ADDR}, {9'b0, b_addr});
            chk("len",  {28'b0, oMEM_LEN}, b_len);
            chk("data", oMEM_DATA, {8'h00, burst[0]});
        end
    endtask

    task automatic model_update(input bit v, input logic [22:0] a, input logic [23:0] d,
                                input bit fl, input bit mb, input bit rs);
        pix_t p;
        bit   had_run;
        p.a = a;
        p.d = d;
        if (rs) begin
            model_clear();
        end else if (burst.size() > 0) begin
            if (!mb) begin
                void'(burst.pop_front());
                if (burst.size() == 0 && pend.size() > 0) begin
                    run.push_back(pend[0]);
                    pend.delete();
                    idle = 0;
                end
            end
        end else begin
            had_run = (run.size() > 0);
            if (v) begin
                if (!had_run) begin
                    run.push_back(p);
                    idle = 0;
                end else if (int'({9'b0, a}) == int'({9'b0, run[0].a}) + run.size()) begin
                    run.push_back(p);
                    idle = 0;
                    if (run.size() == 8 || fl) issue_run();
                end else begin
                    pend.push_back(p);
                    issue_run();
                end
            end else if (had_run) begin
                if (fl) begin
                    issue_run();
                end else begin
                    idle++;
                    if (idle == 15) issue_run();
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, compare, advance model, clock.
    task automatic step(input bit v, input logic [22:0] a, input logic [23:0] d,
                        input bit fl, input bit mb, input bit rs);
        iIF_VALID   = v;
        iIF_ADDR    = a;
        iIF_DATA    = d;
        iFLUSH      = fl;
        iMEM_BUSY   = mb;
        iRESET_SYNC = rs;
        #1;
        model_check();
        model_update(v, a, d, fl, mb, rs);
        @(posedge iCLOCK);
        @(negedge iCLOCK);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 23'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pix(input logic [22:0] a);
        logic [31:0] r;
        r = $urandom;
        step(1'b1, a, r[23:0], 1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int          busy_n;
        int          wait_n;
        int          vprob;
        logic [22:0] last_a;
        logic [22:0] a;
        logic [31:0] r;

        model_clear();
        inRESET     = 1'b0;
        iRESET_SYNC = 1'b0;
        iFLUSH      = 1'b0;
        iIF_VALID   = 1'b0;
        iIF_ADDR    = '0;
        iIF_DATA    = '0;
        iMEM_BUSY   = 1'b0;
        @(negedge iCLOCK);
        @(negedge iCLOCK);

        // Reset state
        chk("rst_busy",  {31'b0, oIF_BUSY},   32'd0);
        chk("rst_valid", {31'b0, oMEM_VALID}, 32'd0);
        chk("rst_last",  {31'b0, oMEM_LAST},  32'd0);
        chk("rst_addr",  {9'b0, oMEM_ADDR},   32'd0);
        chk("rst_len",   {28'b0, oMEM_LEN},   32'd0);
        chk("rst_data",  oMEM_DATA,           32'd0);
        chk("rst_empty", {31'b0, oEMPTY},     32'd1);
        inRESET = 1'b1;
        @(negedge iCLOCK);

        // Full burst back-to-back
        for (int k = 0; k < 8; k++) pix(23'h000100 + 23'(k));
        busy_n = 0;
        for (int k = 0; k < 12; k++) begin
            if (oIF_BUSY === 1'b1) busy_n++;
            idle_steps(1);
        end
        chk("t1_busy_cycles", busy_n, 32'd8);

        // Timeout: a pixel on the 15th idle cycle restarts the timer
        for (int k = 0; k < 3; k++) pix(23'h000200 + 23'(k));
        idle_steps(14);
        pix(23'h000203);
        wait_n = 0;
        while (oMEM_VALID !== 1'b1 && wait_n < 40) begin
            idle_steps(1);
            wait_n++;
        end
        chk("t2_timeout_latency", wait_n + 1, 32'd16);
        idle_steps(6);

        // Address break, then explicit flush of the held pixel
        pix(23'h000300);
        pix(23'h000301);
        pix(23'h000400);
        idle_steps(4);
        step(1'b0, 23'h0, 24'h0, 1'b1, 1'b0, 1'b0);
        idle_steps(3);

        // Flush together with an accepted contiguous pixel
        pix(23'h000450);
        r = $urandom;
        step(1'b1, 23'h000451, r[23:0], 1'b1, 1'b0, 1'b0);
        idle_steps(4);

        // Downstream stall every other cycle
        for (int k = 0; k < 8; k++) pix(23'h000600 + 23'(k));
        for (int k = 0; k < 20; k++) step(1'b0, 23'h0, 24'h0, 1'b0, k[0] == 1'b0, 1'b0);

        // Address wrap is a break
        pix(23'h7FFFFF);
        pix(23'h000000);
        idle_steps(24);

        // Asynchronous reset on the 4th word
        for (int k = 0; k < 8; k++) pix(23'h000500 + 23'(k));
        idle_steps(3);
        inRESET = 1'b0;
        #1;
        chk("arst_valid", {31'b0, oMEM_VALID}, 32'd0);
        chk("arst_busy",  {31'b0, oIF_BUSY},   32'd0);
        chk("arst_empty", {31'b0, oEMPTY},     32'd1);
        model_clear();
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        @(negedge iCLOCK);
        pix(23'h000510);
        step(1'b0, 23'h0, 24'h0, 1'b1, 1'b0, 1'b0);
        idle_steps(3);

        // Synchronous clear on the 4th word
        for (int k = 0; k < 8; k++) pix(23'h000520 + 23'(k));
        idle_steps(3);
        step(1'b0, 23'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        pix(23'h000530);
        step(1'b0, 23'h0, 24'h0, 1'b1, 1'b0, 1'b0);
        idle_steps(3);

        // Randomized traffic
        last_a = 23'h001000;
        vprob  = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) vprob = $urandom_range(5, 95);
            r = $urandom;
            case ($urandom_range(0, 19))
                0, 1:    a = r[22:0];
                2:       a = 23'h7FFFFF;
                3:       a = last_a;
                4:       a = last_a + 23'd2;
                default: a = last_a + 23'd1;
            endcase
            last_a = a;
            r = $urandom;
            step($urandom_range(0, 99) < vprob, a, r[23:0],
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 499) == 0);
        end

        // Drain
        for (int k = 0; k < 60 && (burst.size() > 0 || run.size() > 0); k++)
            step(1'b0, 23'h0, 24'h0, 1'b1, 1'b0, 1'b0);
        idle_steps(2);
        chk("drain_empty", {31'b0, oEMPTY}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
